mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single unified cache port between the fetch stage (instruction reads) and the memory stage (loads/stores). Each requester uses the one-cycle request-pulse / later-ack protocol that fetch already speaks. The block buffers a losing request and serialises transactions to the cache. Data has priority, with a bounded-streak guarantee so fetch is never starved.

## Interface
- `MAX_D_STREAK`, default 4: consecutive data grants allowed while an instruction request waits; range 1–15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_req` in 1: instruction request pulse (fetch `addr_ready`).
- `i_addr` in 32: instruction address, valid with `i_req`.
- `i_ack` out 1: instruction transaction complete.
- `i_rdata` out 32: instruction word, valid with `i_ack`.
- `d_req` in 1: data request pulse.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_be` in 4: store byte enables.
- `d_ack` out 1: data transaction complete.
- `d_rdata` out 32: load data, valid with `d_ack`.
- `c_req` out 1: cache request pulse.
- `c_we` out 1: cache write.
- `c_addr` out 32: cache address.
- `c_wdata` out 32: cache write data.
- `c_be` out 4: cache byte enables.
- `c_ack` in 1: cache completion; may arrive the same cycle as `c_req` (hit).
- `c_rdata` in 32: cache read data.

## Operation
- Each requester has at most one outstanding transaction. It pulses `*_req` for one cycle, then waits for `*_ack`. Any further pulse before the ack is a protocol violation and behaviour is undefined.
- Pending buffers:
  - `pend_i` holds {valid, addr}.
  - `pend_d` holds {valid, we, addr, wdata, be}.
  - A request not issued in its arrival cycle is captured into its buffer on that clock edge.
- Candidate for port X in a cycle: the fresh `X_req` or `pend_X.valid`. The fresh pulse and a valid buffer never coexist.
- FSM states:
  - **IDLE**: no cache transaction outstanding.
    - Select a winner and drive `c_req`=1 combinationally with the winner's fields in the same cycle. Fresh requests are passed through; buffered ones come from `pend`.
    - If `c_ack`=1 in the same cycle: route ack and data to the winner, clear its pend, stay IDLE.
    - Otherwise: go to BUSY_I or BUSY_D and clear the winner's pend. The winner's fields are not needed after issue.
    - The loser, if any, is captured or kept in its pend.
  - **BUSY_I / BUSY_D**: `c_req`=0. Wait for `c_ack`.
    - On `c_ack`: assert `i_ack` or `d_ack` with `c_rdata` for exactly that cycle, then return to IDLE.
    - Fresh requests arriving in BUSY, including on the ack cycle, go to pend.
- Selection in IDLE:
  - Only one candidate: it wins.
  - Both candidates: data wins, unless `d_streak` == `MAX_D_STREAK`, in which case instruction wins.
- `d_streak` (4-bit saturating counter):
  - Increments on each data issue made while an instruction candidate exists.
  - Clears on any instruction issue, and in any IDLE cycle with no instruction candidate.
- Output rules:
  - `c_we`/`c_addr`/`c_wdata`/`c_be` are 0 whenever `c_req`=0.
  - For instruction issues, `c_we`=0 and `c_be`=4'hF.
  - `i_rdata`/`d_rdata` are 0 when their ack is low.
- Reset (asynchronous, any state):
  - state=IDLE; both pends invalid; `d_streak`=0.
  - All outputs 0.
  - Any cache transaction in flight at reset is abandoned. The cache shares `rst`, so no stale `c_ack` follows.

## Timing
- Cache hit from IDLE: zero added latency. Request, `c_req`, `c_ack` and `*_ack` all occur in the same cycle.
- Cache miss with latency L cycles after `c_req`: `*_ack` appears L cycles after the request.
- Request blocked by a busy port: issued in the first IDLE cycle after the blocking ack. There is one IDLE issue cycle after each BUSY, so at least one cycle is added.
- Back-to-back hits on both ports arriving together: data acks in cycle 0, instruction issues and acks in cycle 1.
- Worst-case instruction wait: `MAX_D_STREAK` data transactions plus the in-flight one.
- No combinational path from `c_ack` to `c_req`. Combinational paths exist from `*_req`/fields to `c_*`, and from `c_ack`/`c_rdata` to `*_ack`/`*_rdata`.

## Test plan
- **Single instruction hit:**
  - Stimulus: IDLE, `i_req`=1, `i_addr`=0x100, `c_ack`=1 with `c_rdata`=0x00000013 in the same cycle.
  - Response: `c_req`=1, `c_addr`=0x100, `c_we`=0; `i_ack`=1 with `i_rdata`=0x13 that cycle; `d_ack`=0.
- **Simultaneous requests:**
  - Stimulus: `i_req` (0x200) and `d_req` load (0x8000) in the same cycle; cache always hits.
  - Response: cycle 0 `c_addr`=0x8000 and `d_ack`; cycle 1 `c_addr`=0x200 and `i_ack`.
- **Request during a miss:**
  - Stimulus: `d_req` store (0x40, wdata 0xDEADBEEF, be 4'b0011) misses with a 3-cycle latency; `i_req` 0x300 arrives at cycle 1.
  - Response: `c_we`=1 and `c_be`=0011 on issue; `d_ack` at cycle 3; instruction issued at cycle 4 with `c_req`=1 and `c_addr`=0x300.
- **Starvation bound:**
  - Stimulus: `MAX_D_STREAK`=2; `i_req` pending while a data request is presented in every IDLE cycle; all hits.
  - Response: grant order D, D, I, D, D, I…; `d_streak` never exceeds 2.
- **Reset mid-operation:**
  - Stimulus: assert `rst` in BUSY_D with `pend_i` valid.
  - Response: all outputs 0 immediately and no later `i_ack`/`d_ack`; after release, a fresh `i_req` is served normally.
- **Same-cycle hand-off:**
  - Stimulus: `c_ack` for an instruction miss in the same cycle as a new `d_req`.
  - Response: `i_ack`=1 that cycle; `d_req` is issued the next cycle from `pend_d` with its original fields.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified cache port between instruction fetch and data access.
// Data has priority, but a bounded data-grant streak keeps a waiting fetch from starving.
module mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        c_req,
    output logic        c_we,
    output logic [31:0] c_addr,
    output logic [31:0] c_wdata,
    output logic [3:0]  c_be,
    input  logic        c_ack,
    input  logic [31:0] c_rdata
);

    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        pi_v_q, pi_v_d;
    logic [31:0] pi_addr_q, pi_addr_d;
    logic        pd_v_q, pd_v_d;
    logic        pd_we_q, pd_we_d;
    logic [31:0] pd_addr_q, pd_addr_d;
    logic [31:0] pd_wdata_q, pd_wdata_d;
    logic [3:0]  pd_be_q, pd_be_d;
    logic [3:0]  streak_q, streak_d;

    logic idle, i_cand, d_cand, grant_i, grant_d;

    always_comb begin
        // Issue decisions depend only on state and requests, never on c_ack.
        idle    = (state_q == IDLE) && !rst;
        i_cand  = i_req || pi_v_q;
        d_cand  = d_req || pd_v_q;
        grant_d = idle && d_cand && !(i_cand && (streak_q == MAX_S));
        grant_i = idle && i_cand && !grant_d;

        c_req   = 1'b0;
        c_we    = 1'b0;
        c_addr  = '0;
        c_wdata = '0;
        c_be    = '0;
        if (grant_d) begin
            c_req   = 1'b1;
            c_we    = pd_v_q ? pd_we_q    : d_we;
            c_addr  = pd_v_q ? pd_addr_q  : d_addr;
            c_wdata = pd_v_q ? pd_wdata_q : d_wdata;
            c_be    = pd_v_q ? pd_be_q    : d_be;
        end else if (grant_i) begin
            c_req  = 1'b1;
            c_addr = pi_v_q ? pi_addr_q : i_addr;
            c_be   = '1;
        end

        i_ack   = !rst && c_ack && (grant_i || (state_q == BUSY_I));
        d_ack   = !rst && c_ack && (grant_d || (state_q == BUSY_D));
        i_rdata = i_ack ? c_rdata : '0;
        d_rdata = d_ack ? c_rdata : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d && !c_ack)      state_d = BUSY_D;
                else if (grant_i && !c_ack) state_d = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (c_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pi_v_d     = pi_v_q;
        pi_addr_d  = pi_addr_q;
        pd_v_d     = pd_v_q;
        pd_we_d    = pd_we_q;
        pd_addr_d  = pd_addr_q;
        pd_wdata_d = pd_wdata_q;
        pd_be_d    = pd_be_q;
        streak_d   = streak_q;

        if (grant_i) begin
            pi_v_d = 1'b0;
        end else if (i_req) begin
            pi_v_d    = 1'b1;
            pi_addr_d = i_addr;
        end

        if (grant_d) begin
            pd_v_d = 1'b0;
        end else if (d_req) begin
            pd_v_d     = 1'b1;
            pd_we_d    = d_we;
            pd_addr_d  = d_addr;
            pd_wdata_d = d_wdata;
            pd_be_d    = d_be;
        end

        // Streak counts data grants that bypassed a waiting fetch.
        if (idle) begin
            if (grant_i || !i_cand)
                streak_d = '0;
            else if (grant_d && (streak_q != 4'hF))
                streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pi_v_q     <= 1'b0;
            pi_addr_q  <= '0;
            pd_v_q     <= 1'b0;
            pd_we_q    <= 1'b0;
            pd_addr_q  <= '0;
            pd_wdata_q <= '0;
            pd_be_q    <= '0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            pi_v_q     <= pi_v_d;
            pi_addr_q  <= pi_addr_d;
            pd_v_q     <= pd_v_d;
            pd_we_q    <= pd_we_d;
            pd_addr_q  <= pd_addr_d;
            pd_wdata_q <= pd_wdata_d;
            pd_be_q    <= pd_be_d;
            streak_q   <= streak_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays the cache and checks every
// cycle against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int MAXS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, c_ack;
    logic [31:0] i_addr, d_addr, d_wdata, c_rdata;
    logic [3:0]  d_be;
    logic        i_ack, d_ack, c_req, c_we;
    logic [31:0] i_rdata, d_rdata, c_addr, c_wdata;
    logic [3:0]  c_be;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_ack(c_ack), .c_rdata(c_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the cache, how long until it answers, who waits.
    int          m_owner;      // 0 none, 1 instruction, 2 data
    int          m_left;
    bit          mi_wait, md_wait, md_we;
    logic [31:0] mi_addr, md_addr, md_wdata;
    logic [3:0]  md_be;
    int          m_streak;
    bit          i_out, d_out;
    int          grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_owner = 0; m_left = 0; mi_wait = 0; md_wait = 0; m_streak = 0;
        i_out = 0; d_out = 0;
    endtask

    task automatic step(input bit ireq, input logic [31:0] iaddr, input bit dreq, input bit dwe,
                        input logic [31:0] daddr, input logic [31:0] dwdata, input logic [3:0] dbe,
                        input int lat, input logic [31:0] rd);
        bit          ir, dr, ic, dc, e_ia, e_da, e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        int          win;
        ir = ireq && !i_out;
        dr = dreq && !d_out;
        win = 0; e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0; e_ia = 0; e_da = 0;
        if (m_owner == 0) begin
            ic = ir || mi_wait;
            dc = dr || md_wait;
            if (dc && !(ic && m_streak == MAXS)) win = 2;
            else if (ic)                         win = 1;
            if (win == 2) begin
                e_req = 1;
                e_we    = md_wait ? md_we    : dwe;
                e_addr  = md_wait ? md_addr  : daddr;
                e_wdata = md_wait ? md_wdata : dwdata;
                e_be    = md_wait ? md_be    : dbe;
            end else if (win == 1) begin
                e_req = 1;
                e_addr = mi_wait ? mi_addr : iaddr;
                e_be = 4'hF;
            end
            if (win == 1 || !ic) m_streak = 0;
            else if (win == 2 && m_streak < 15) m_streak++;
            if (win != 0) begin
                grants.push_back(win);
                if (lat == 0) begin
                    e_ia = (win == 1);
                    e_da = (win == 2);
                end else begin
                    m_owner = win;
                    m_left = lat;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                e_ia = (m_owner == 1);
                e_da = (m_owner == 2);
                m_owner = 0;
            end
        end
        if (win == 1) mi_wait = 0;
        else if (ir) begin mi_wait = 1; mi_addr = iaddr; end
        if (win == 2) md_wait = 0;
        else if (dr) begin
            md_wait = 1; md_we = dwe; md_addr = daddr; md_wdata = dwdata; md_be = dbe;
        end
        if (ir) i_out = 1;
        if (e_ia) i_out = 0;
        if (dr) d_out = 1;
        if (e_da) d_out = 0;

        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_req   = ir;
        i_addr  = ir ? iaddr : $urandom;
        d_req   = dr;
        d_we    = dr ? dwe : 1'($urandom);
        d_addr  = dr ? daddr : $urandom;
        d_wdata = dr ? dwdata : $urandom;
        d_be    = dr ? dbe : 4'($urandom);
        c_ack   = e_ia || e_da;
        c_rdata = rd;
        #3;
        chk("c_req",   {31'b0, c_req}, {31'b0, e_req});
        chk("c_we",    {31'b0, c_we},  {31'b0, e_we});
        chk("c_addr",  c_addr,  e_addr);
        chk("c_wdata", c_wdata, e_wdata);
        chk("c_be",    {28'b0, c_be}, {28'b0, e_be});
        chk("i_ack",   {31'b0, i_ack}, {31'b0, e_ia});
        chk("i_rdata", i_rdata, e_ia ? rd : 32'h0);
        chk("d_ack",   {31'b0, d_ack}, {31'b0, e_da});
        chk("d_rdata", d_rdata, e_da ? rd : 32'h0);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, ".c_req"},   {31'b0, c_req}, 32'h0);
        chk({tag, ".c_we"},    {31'b0, c_we},  32'h0);
        chk({tag, ".c_addr"},  c_addr,  32'h0);
        chk({tag, ".c_wdata"}, c_wdata, 32'h0);
        chk({tag, ".c_be"},    {28'b0, c_be}, 32'h0);
        chk({tag, ".i_ack"},   {31'b0, i_ack}, 32'h0);
        chk({tag, ".i_rdata"}, i_rdata, 32'h0);
        chk({tag, ".d_ack"},   {31'b0, d_ack}, 32'h0);
        chk({tag, ".d_rdata"}, d_rdata, 32'h0);
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; c_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; c_rdata = 0;
        #1;
        check_outputs_zero(tag);
        model_clear();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; c_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; c_rdata = 0;
        model_clear();
        #12;
        check_outputs_zero("reset");
        rst = 1'b0;

        // single instruction hit
        step(1, 32'h100, 0, 0, 0, 0, 0, 0, 32'h00000013);
        idle_step();

        // simultaneous requests: data first, instruction next cycle
        step(1, 32'h200, 1, 0, 32'h8000, 0, 4'hF, 0, $urandom);
        step(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
        idle_step();

        // store miss of latency 3 with an instruction arriving meanwhile
        step(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 4'b0011, 3, $urandom);
        step(1, 32'h300, 0, 0, 0, 0, 0, 0, $urandom);
        idle_step();
        idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
        idle_step();

        // instruction miss ack coinciding with a new data request
        step(1, 32'h500, 0, 0, 0, 0, 0, 2, $urandom);
        idle_step();
        step(0, 0, 1, 1, 32'h600, 32'h12345678, 4'b1100, 0, $urandom);
        step(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
        idle_step();
        idle_step();

        // starvation bound: continuous data pressure with fetch waiting
        grants.delete();
        for (int k = 0; k < 9; k++)
            step(1, 32'h1000 + 32'(k * 4), 1, 0, 32'h9000 + 32'(k * 4), 0, 4'hF, 0, $urandom);
        for (int k = 0; k < 9; k++)
            chk("grant_order", 32'(grants[k]), (k % 3 == 2) ? 32'd1 : 32'd2);
        idle_step();
        idle_step();

        // reset while a data miss is in flight with a fetch waiting
        step(0, 0, 1, 0, 32'h44, 0, 4'hF, 6, $urandom);
        step(1, 32'h700, 0, 0, 0, 0, 0, 0, $urandom);
        apply_reset("midreset");
        for (int k = 0; k < 8; k++) idle_step();
        step(1, 32'h800, 0, 0, 0, 0, 0, 1, $urandom);
        idle_step();

        // randomized traffic with mixed hit/miss latencies
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 99) < 45), $urandom, ($urandom_range(0, 99) < 55), 1'($urandom),
                 $urandom, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom);
        for (int k = 0; k < 6; k++) idle_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
